// File: rtl/lockstep_instr_feeder.sv
// Drives one stored program into NUM_CH valid/ready channels, stalling a channel after each load/store
// and latching the first RUN cycle on which the channels' ready inputs disagree. Option: LOCKSTEP_SYNC_EN.
module lockstep_instr_feeder #(
    parameter int NUM_CH     = 2,
    parameter int PROG_DEPTH = 4,
    parameter int INSTR_W    = 32,
    parameter int MEMOP_GAP  = 1,
    parameter int CYC_W      = 16,
    localparam int AW        = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic                        prog_we_i,
    input  logic [AW-1:0]               prog_waddr_i,
    input  logic [INSTR_W-1:0]          prog_wdata_i,
    output logic [NUM_CH*INSTR_W-1:0]   instr_o,
    output logic [NUM_CH-1:0]           instr_valid_o,
    input  logic [NUM_CH-1:0]           instr_ready_i,
    output logic [NUM_CH-1:0]           ch_done_o,
    output logic                        busy_o,
    output logic                        diverge_o,
    output logic [CYC_W-1:0]            diverge_cycle_o,
    output logic [NUM_CH-1:0]           diverge_mask_o
);

    localparam int              PCW      = $clog2(PROG_DEPTH + 1);
    localparam int              GW       = (MEMOP_GAP > 0) ? $clog2(MEMOP_GAP + 1) : 1;
    localparam logic [PCW-1:0]  PC_END   = PCW'(PROG_DEPTH);
    localparam logic [GW-1:0]   GAP_LD   = GW'(MEMOP_GAP);
    localparam logic [6:0]      OP_LOAD  = 7'b0000011;
    localparam logic [6:0]      OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e                 state_q, state_d;
    logic [INSTR_W-1:0]     prog_q [PROG_DEPTH];
    logic [INSTR_W-1:0]     prog_d [PROG_DEPTH];
    logic [PCW-1:0]         pc_q   [NUM_CH];
    logic [PCW-1:0]         pc_d   [NUM_CH];
    logic [GW-1:0]          gap_q  [NUM_CH];
    logic [GW-1:0]          gap_d  [NUM_CH];
    logic [CYC_W-1:0]       cyc_q, cyc_d;
    logic                   div_q, div_d;
    logic [CYC_W-1:0]       div_cyc_q, div_cyc_d;
    logic [NUM_CH-1:0]      div_mask_q, div_mask_d;

    logic [NUM_CH-1:0]          vld;
    logic [NUM_CH-1:0]          xfer;
    logic [NUM_CH*INSTR_W-1:0]  instr;
    logic                       all_done;

`ifdef LOCKSTEP_SYNC_EN
    logic [PCW-1:0]             min_pc;
    logic                       gaps_clear;
`endif

    function automatic logic is_memop(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    // Offer logic looks only at registered state, so valid never depends on ready.
    always_comb begin
        instr     = '0;
        vld       = '0;
        ch_done_o = '0;
`ifdef LOCKSTEP_SYNC_EN
        min_pc     = PC_END;
        gaps_clear = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (pc_q[c] < PC_END) begin
                if (pc_q[c] < min_pc) min_pc = pc_q[c];
                if (gap_q[c] != '0) gaps_clear = 1'b0;
            end
        end
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            for (int s = 0; s < PROG_DEPTH; s++) begin
                if (pc_q[c] == PCW'(s)) instr[c*INSTR_W +: INSTR_W] = prog_q[s];
            end
            vld[c] = (state_q == S_RUN) && (gap_q[c] == '0) && (pc_q[c] < PC_END)
`ifdef LOCKSTEP_SYNC_EN
                     && (pc_q[c] == min_pc) && gaps_clear
`endif
                     ;
            ch_done_o[c] = (pc_q[c] == PC_END);
        end
    end

    always_comb begin
        state_d    = state_q;
        prog_d     = prog_q;
        pc_d       = pc_q;
        gap_d      = gap_q;
        cyc_d      = cyc_q;
        div_d      = div_q;
        div_cyc_d  = div_cyc_q;
        div_mask_d = div_mask_q;
        xfer       = vld & instr_ready_i;
        all_done   = 1'b1;
        case (state_q)
            S_RUN: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (gap_q[c] != '0) gap_d[c] = gap_q[c] - GW'(1);
                    if (xfer[c]) begin
                        pc_d[c] = pc_q[c] + PCW'(1);
                        if (is_memop(instr[c*INSTR_W +: 7])) gap_d[c] = GAP_LD;
                    end
                    if (pc_d[c] != PC_END) all_done = 1'b0;
                end
                if (cyc_q != '1) cyc_d = cyc_q + CYC_W'(1);
                if (!div_q && (instr_ready_i != '0) && (instr_ready_i != '1)) begin
                    div_d      = 1'b1;
                    div_cyc_d  = cyc_q;
                    div_mask_d = instr_ready_i;
                end
                // Leave RUN in the same cycle the last transfer lands.
                if (all_done) state_d = S_DONE;
            end
            default: begin
                if (prog_we_i) begin
                    for (int s = 0; s < PROG_DEPTH; s++) begin
                        if (prog_waddr_i == AW'(s)) prog_d[s] = prog_wdata_i;
                    end
                end
                if (start_i) begin
                    state_d    = S_RUN;
                    pc_d       = '{default: '0};
                    gap_d      = '{default: '0};
                    cyc_d      = '0;
                    div_d      = 1'b0;
                    div_cyc_d  = '0;
                    div_mask_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            prog_q     <= '{default: '0};
            pc_q       <= '{default: '0};
            gap_q      <= '{default: '0};
            cyc_q      <= '0;
            div_q      <= 1'b0;
            div_cyc_q  <= '0;
            div_mask_q <= '0;
        end else begin
            state_q    <= state_d;
            prog_q     <= prog_d;
            pc_q       <= pc_d;
            gap_q      <= gap_d;
            cyc_q      <= cyc_d;
            div_q      <= div_d;
            div_cyc_q  <= div_cyc_d;
            div_mask_q <= div_mask_d;
        end
    end

    assign instr_o         = instr;
    assign instr_valid_o   = vld;
    assign busy_o          = (state_q == S_RUN);
    assign diverge_o       = div_q;
    assign diverge_cycle_o = div_cyc_q;
    assign diverge_mask_o  = div_mask_q;

endmodule

// File: tb/tb_lockstep_instr_feeder.sv
// Randomised and directed bench for lockstep_instr_feeder against a transaction-level model.
module tb_lockstep_instr_feeder;

    localparam int NUM_CH     = 2;
    localparam int PROG_DEPTH = 4;
    localparam int INSTR_W    = 32;
    localparam int MEMOP_GAP  = 1;
    localparam int CYC_W      = 16;
    localparam int AW         = 2;
    localparam int OW         = 3 * NUM_CH + NUM_CH * INSTR_W + 2 + CYC_W;

    localparam logic [31:0] I_ADDI0 = 32'h00100093;
    localparam logic [31:0] I_SW    = 32'h00102023;
    localparam logic [31:0] I_LW    = 32'h00002103;
    localparam logic [31:0] I_ADDI1 = 32'h00208193;
    localparam logic [31:0] I_NEW   = 32'h00500313;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic                       clk_i = 1'b0;
    logic                       rst_ni = 1'b0;
    logic                       start_i = 1'b0;
    logic                       prog_we_i = 1'b0;
    logic [AW-1:0]              prog_waddr_i = '0;
    logic [INSTR_W-1:0]         prog_wdata_i = '0;
    logic [NUM_CH*INSTR_W-1:0]  instr_o;
    logic [NUM_CH-1:0]          instr_valid_o;
    logic [NUM_CH-1:0]          instr_ready_i = '0;
    logic [NUM_CH-1:0]          ch_done_o;
    logic                       busy_o;
    logic                       diverge_o;
    logic [CYC_W-1:0]           diverge_cycle_o;
    logic [NUM_CH-1:0]          diverge_mask_o;

    always #5 clk_i = ~clk_i;

    lockstep_instr_feeder #(
        .NUM_CH(NUM_CH), .PROG_DEPTH(PROG_DEPTH), .INSTR_W(INSTR_W),
        .MEMOP_GAP(MEMOP_GAP), .CYC_W(CYC_W)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .prog_we_i(prog_we_i), .prog_waddr_i(prog_waddr_i), .prog_wdata_i(prog_wdata_i),
        .instr_o(instr_o), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .ch_done_o(ch_done_o), .busy_o(busy_o), .diverge_o(diverge_o),
        .diverge_cycle_o(diverge_cycle_o), .diverge_mask_o(diverge_mask_o)
    );

    logic [OW-1:0] dut_outs;
    assign dut_outs = {instr_valid_o, instr_o, ch_done_o, busy_o, diverge_o, diverge_cycle_o, diverge_mask_o};

    int errors = 0;
    int checks = 0;

    // Reference model: per-channel issue index and stall countdown.
    int                 m_state;
    int                 m_idx [NUM_CH];
    int                 m_gap [NUM_CH];
    int                 m_cyc;
    int                 m_dcyc;
    bit                 m_div;
    logic [NUM_CH-1:0]  m_dmask;
    logic [INSTR_W-1:0] m_prog [PROG_DEPTH];

    function automatic bit is_mem(logic [INSTR_W-1:0] w);
        return (w[6:0] == 7'b0000011) || (w[6:0] == 7'b0100011);
    endfunction

    function automatic bit offered(int c);
`ifdef LOCKSTEP_SYNC_EN
        int lowest = PROG_DEPTH;
        bit gaps_clear = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (m_idx[k] < PROG_DEPTH) begin
                if (m_idx[k] < lowest) lowest = m_idx[k];
                if (m_gap[k] != 0) gaps_clear = 1'b0;
            end
        end
        return m_state == M_RUN && m_gap[c] == 0 && m_idx[c] < PROG_DEPTH && m_idx[c] == lowest && gaps_clear;
`else
        return m_state == M_RUN && m_gap[c] == 0 && m_idx[c] < PROG_DEPTH;
`endif
    endfunction

    function automatic logic [OW-1:0] exp_outs();
        logic [NUM_CH-1:0]         v;
        logic [NUM_CH-1:0]         d;
        logic [NUM_CH*INSTR_W-1:0] ins;
        v = '0; d = '0; ins = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            v[c] = offered(c);
            d[c] = (m_idx[c] == PROG_DEPTH);
            if (m_idx[c] < PROG_DEPTH) ins[c*INSTR_W +: INSTR_W] = m_prog[m_idx[c]];
        end
        return {v, ins, d, m_state == M_RUN, m_div, CYC_W'(m_dcyc), m_dmask};
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_cyc = 0; m_dcyc = 0; m_div = 0; m_dmask = '0;
        for (int c = 0; c < NUM_CH; c++) begin m_idx[c] = 0; m_gap[c] = 0; end
        for (int s = 0; s < PROG_DEPTH; s++) m_prog[s] = '0;
    endtask

    // Advances the model by one clock using the inputs currently driven, then clocks the DUT.
    task automatic tick();
        logic [NUM_CH-1:0] rdy;
        bit off [NUM_CH];
        bit fin;
        rdy = instr_ready_i;
        for (int c = 0; c < NUM_CH; c++) off[c] = offered(c);
        if (m_state != M_RUN) begin
            if (prog_we_i && int'(prog_waddr_i) < PROG_DEPTH) m_prog[prog_waddr_i] = prog_wdata_i;
            if (start_i) begin
                m_state = M_RUN; m_cyc = 0; m_dcyc = 0; m_div = 0; m_dmask = '0;
                for (int c = 0; c < NUM_CH; c++) begin m_idx[c] = 0; m_gap[c] = 0; end
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (m_gap[c] > 0) m_gap[c]--;
                if (off[c] && rdy[c]) begin
                    if (is_mem(m_prog[m_idx[c]])) m_gap[c] = MEMOP_GAP;
                    m_idx[c]++;
                end
            end
            if (!m_div && rdy != '0 && rdy != '1) begin
                m_div = 1; m_dcyc = m_cyc; m_dmask = rdy;
            end
            if (m_cyc < (1 << CYC_W) - 1) m_cyc++;
            fin = 1;
            for (int c = 0; c < NUM_CH; c++) if (m_idx[c] != PROG_DEPTH) fin = 0;
            if (fin) m_state = M_DONE;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_prog(input logic [31:0] w0, w1, w2, w3);
        logic [31:0] w [4];
        w = '{w0, w1, w2, w3};
        for (int i = 0; i < 4; i++) begin
            prog_we_i = 1'b1; prog_waddr_i = AW'(i); prog_wdata_i = w[i];
            tick();
        end
        prog_we_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (dut_outs !== '0) begin errors++; $display("FAIL reset_outs: got=%h want=0", dut_outs); end
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        instr_ready_i = '1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dut_outs !== exp_outs()) begin errors++; $display("FAIL idle_after_reset: got=%h want=%h", dut_outs, exp_outs()); end
        end
    endtask

    task automatic test_basic();
        int n = 0;
        load_prog(I_ADDI0, I_SW, I_LW, I_ADDI1);
        instr_ready_i = '1;
        pulse_start();
        while (busy_o && n < 40) begin
            checks++;
            if (dut_outs !== exp_outs()) begin errors++; $display("FAIL basic_cycle%0d: got=%h want=%h", n, dut_outs, exp_outs()); end
            tick(); n++;
        end
        checks++;
        if (n != 6) begin errors++; $display("FAIL basic_run_len: got=%0d want=6", n); end
        checks++;
        if (ch_done_o !== 2'b11) begin errors++; $display("FAIL basic_done: got=%b want=11", ch_done_o); end
        checks++;
        if (diverge_o !== 1'b0) begin errors++; $display("FAIL basic_diverge: got=%b want=0", diverge_o); end
    endtask

    task automatic test_diverge();
        int k = 0;
        pulse_start();
        while (busy_o && k < 40) begin
            checks++;
            if (dut_outs !== exp_outs()) begin errors++; $display("FAIL diverge_cycle%0d: got=%h want=%h", k, dut_outs, exp_outs()); end
            instr_ready_i = (k == 3) ? 2'b01 : (k == 5) ? 2'b10 : 2'b11;
            tick(); k++;
        end
        instr_ready_i = '1;
        checks++;
        if ({diverge_o, diverge_cycle_o, diverge_mask_o} !== {1'b1, 16'd3, 2'b01})
            begin errors++; $display("FAIL diverge_latch: got=%b/%0d/%b want=1/3/01", diverge_o, diverge_cycle_o, diverge_mask_o); end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL diverge_timeout: busy=%b want=0", busy_o); end
    endtask

    task automatic test_hold();
        int k = 0;
        instr_ready_i = '0;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({instr_valid_o, instr_o} !== {2'b11, I_ADDI0, I_ADDI0})
                begin errors++; $display("FAIL hold_stable%0d: got=%b/%h want=11/%h", i, instr_valid_o, instr_o, {I_ADDI0, I_ADDI0}); end
            checks++;
            if (dut_outs !== exp_outs()) begin errors++; $display("FAIL hold_model%0d: got=%h want=%h", i, dut_outs, exp_outs()); end
            tick();
        end
        instr_ready_i = '1;
        while (busy_o && k < 40) begin tick(); k++; end
        checks++;
        if (dut_outs !== exp_outs()) begin errors++; $display("FAIL hold_end: got=%h want=%h", dut_outs, exp_outs()); end
    endtask

    task automatic test_prog_write();
        logic [31:0] want;
        for (int run = 0; run < 2; run++) begin
            int k = 0;
            want = (run == 0) ? I_LW : I_NEW;
            if (run == 1) begin
                prog_we_i = 1'b1; prog_waddr_i = 2'd2; prog_wdata_i = I_NEW;
                tick();
                prog_we_i = 1'b0;
            end
            instr_ready_i = '1;
            pulse_start();
            while (busy_o && k < 40) begin
                checks++;
                if (dut_outs !== exp_outs()) begin errors++; $display("FAIL pwrite%0d_cycle%0d: got=%h want=%h", run, k, dut_outs, exp_outs()); end
                if (k == 3) begin
                    checks++;
                    if ({instr_valid_o[0], instr_o[31:0]} !== {1'b1, want})
                        begin errors++; $display("FAIL pwrite%0d_slot2: got=%b/%h want=1/%h", run, instr_valid_o[0], instr_o[31:0], want); end
                end
                prog_we_i = (run == 0 && k == 0); prog_waddr_i = 2'd2; prog_wdata_i = I_NEW;
                tick(); k++;
                prog_we_i = 1'b0;
            end
        end
    endtask

    task automatic test_sync();
        int k = 0;
        logic [1:0] want1, want3;
`ifdef LOCKSTEP_SYNC_EN
        want1 = 2'b10; want3 = 2'b10;
`else
        want1 = 2'b11; want3 = 2'b11;
`endif
        load_prog(I_ADDI0, I_SW, I_LW, I_ADDI1);
        pulse_start();
        while (busy_o && k < 40) begin
            checks++;
            if (dut_outs !== exp_outs()) begin errors++; $display("FAIL sync_cycle%0d: got=%h want=%h", k, dut_outs, exp_outs()); end
            if (k == 1 || k == 3) begin
                checks++;
                if (instr_valid_o !== ((k == 1) ? want1 : want3))
                    begin errors++; $display("FAIL sync_valid%0d: got=%b want=%b", k, instr_valid_o, (k == 1) ? want1 : want3); end
            end
            instr_ready_i = (k < 3) ? 2'b01 : 2'b11;
            tick(); k++;
        end
        instr_ready_i = '1;
    endtask

    task automatic test_reset_mid_run();
        int k = 0;
        instr_ready_i = '1;
        pulse_start();
        tick(); tick();
        checks++;
        if (dut_outs !== exp_outs()) begin errors++; $display("FAIL midrun_pre: got=%h want=%h", dut_outs, exp_outs()); end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (dut_outs !== '0) begin errors++; $display("FAIL midrun_async: got=%h want=0", dut_outs); end
        model_reset();
        #1;
        rst_ni = 1'b1;
        tick();
        checks++;
        if (dut_outs !== exp_outs()) begin errors++; $display("FAIL midrun_idle: got=%h want=%h", dut_outs, exp_outs()); end
        load_prog(I_ADDI0, I_SW, I_LW, I_ADDI1);
        pulse_start();
        checks++;
        if ({instr_valid_o, instr_o} !== {2'b11, I_ADDI0, I_ADDI0})
            begin errors++; $display("FAIL midrun_restart: got=%b/%h want=11/%h", instr_valid_o, instr_o, {I_ADDI0, I_ADDI0}); end
        while (busy_o && k < 40) begin
            checks++;
            if (dut_outs !== exp_outs()) begin errors++; $display("FAIL midrun_cycle%0d: got=%h want=%h", k, dut_outs, exp_outs()); end
            tick(); k++;
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [4];
        logic [31:0] r;
        ops = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
        for (int i = 0; i < 1500; i++) begin
            checks++;
            if (dut_outs !== exp_outs()) begin errors++; $display("FAIL rand_cycle%0d: got=%h want=%h", i, dut_outs, exp_outs()); end
            r = $urandom();
            start_i       = busy_o ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
            prog_we_i     = ($urandom_range(0, 3) == 0);
            prog_waddr_i  = AW'($urandom_range(0, 3));
            prog_wdata_i  = {r[31:7], ops[$urandom_range(0, 3)]};
            instr_ready_i = ($urandom_range(0, 1) == 0) ? 2'b11 : NUM_CH'($urandom_range(0, 3));
            tick();
        end
        start_i = 1'b0; prog_we_i = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_diverge();
        test_hold();
        test_prog_write();
        test_sync();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
